// File: rtl/processor.sv
// rtl/processor.sv - single-cycle 18-bit processor with register file and companion data ram
module processor_regs #(
    parameter int WORD_SIZE = 18
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [2:0]           sel_a,
    input  logic [2:0]           sel_b,
    input  logic [2:0]           sel_c,
    input  logic                 write,
    input  logic [WORD_SIZE-1:0] write_data,
    output logic [WORD_SIZE-1:0] val_a,
    output logic [WORD_SIZE-1:0] val_b,
    output logic [WORD_SIZE-1:0] val_c
);
    logic [WORD_SIZE-1:0] regs [0:7];

    assign val_a = regs[sel_a];
    assign val_b = regs[sel_b];
    assign val_c = regs[sel_c];

    // The destination is always the A field, so it doubles as the write index.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else if (write) begin
            regs[sel_a] <= write_data;
        end
    end
endmodule

module processor #(
    parameter int ADDR_SIZE = 18,
    parameter int WORD_SIZE = 18
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic [ADDR_SIZE-1:0] code_addr,
    input  logic [WORD_SIZE-1:0] code_word,
    output logic                 memory_write_enable,
    output logic [ADDR_SIZE-1:0] memory_addr,
    output logic [WORD_SIZE-1:0] memory_in,
    input  logic [WORD_SIZE-1:0] memory_out
);
    logic [ADDR_SIZE-1:0] pc;
    logic [ADDR_SIZE-1:0] pc_next;
    logic [ADDR_SIZE-1:0] pc_inc;
    logic [ADDR_SIZE-1:0] eff_addr;
    logic [ADDR_SIZE-1:0] imm8_addr;
    logic [WORD_SIZE-1:0] imm8_word;
    logic [WORD_SIZE-1:0] imm11_word;
    logic [WORD_SIZE-1:0] val_a, val_b, val_c;
    logic [WORD_SIZE-1:0] alu_result;
    logic [WORD_SIZE-1:0] reg_data;
    logic                 reg_write;
    logic                 store;
    logic                 taken;
    logic                 b_neg, b_zero;

    logic [3:0] op;
    logic [2:0] sel_a, sel_b, sel_c;
    logic [3:0] alu_op;
    logic [7:0] imm8;
    logic [10:0] imm11;

    assign op     = code_word[17:14];
    assign sel_a  = code_word[13:11];
    assign sel_b  = code_word[10:8];
    assign sel_c  = code_word[7:5];
    assign alu_op = code_word[3:0];
    assign imm8   = code_word[7:0];
    assign imm11  = code_word[10:0];

    assign imm8_word  = {{(WORD_SIZE-8){imm8[7]}}, imm8};
    assign imm11_word = {{(WORD_SIZE-11){imm11[10]}}, imm11};
    assign imm8_addr  = {{(ADDR_SIZE-8){imm8[7]}}, imm8};
    assign eff_addr   = ADDR_SIZE'(val_b) + imm8_addr;
    assign pc_inc     = pc + ADDR_SIZE'(1);
    assign code_addr  = pc;

    processor_regs #(.WORD_SIZE(WORD_SIZE)) registers (
        .clock      (clock),
        .reset      (reset),
        .sel_a      (sel_a),
        .sel_b      (sel_b),
        .sel_c      (sel_c),
        .write      (reg_write),
        .write_data (reg_data),
        .val_a      (val_a),
        .val_b      (val_b),
        .val_c      (val_c)
    );

    always_comb begin
        alu_result = val_b;
        case (alu_op)
            4'd0: alu_result = val_b + val_c;
            4'd1: alu_result = val_b - val_c;
            4'd2: alu_result = val_b & val_c;
            4'd3: alu_result = val_b | val_c;
            4'd4: alu_result = val_b ^ val_c;
            4'd5: alu_result = ~val_c;
            default: alu_result = val_b;
        endcase
    end

    assign b_neg  = val_b[WORD_SIZE-1];
    assign b_zero = (val_b == '0);

    always_comb begin
        taken = 1'b1;
        case (sel_a)
            3'd0: taken = b_zero;
            3'd1: taken = b_neg;
            3'd2: taken = !b_neg && !b_zero;
            3'd3: taken = b_neg || b_zero;
            3'd4: taken = !b_neg;
            3'd5: taken = !val_b[0];
            3'd6: taken = val_b[0];
            default: taken = 1'b1;
        endcase
    end

    always_comb begin
        reg_write   = 1'b0;
        reg_data    = '0;
        store       = 1'b0;
        memory_addr = '0;
        memory_in   = '0;
        pc_next     = pc_inc;
        case (op)
            4'd0: begin
                reg_write = 1'b1;
                reg_data  = alu_result;
            end
            4'd1: begin
                reg_write = 1'b1;
                reg_data  = imm11_word;
            end
            4'd2: begin
                reg_write = 1'b1;
                reg_data  = val_a + imm8_word;
            end
            4'd3: begin
                memory_addr = eff_addr;
                reg_write   = 1'b1;
                reg_data    = memory_out;
            end
            4'd4: begin
                memory_addr = eff_addr;
                memory_in   = val_a;
                store       = 1'b1;
            end
            4'd5: begin
                if (taken) pc_next = pc_inc + imm8_addr;
            end
            default: ;
        endcase
    end

    // Reset must suppress the strobe combinationally so an aborted STORE never lands.
    assign memory_write_enable = store && !reset;

    always_ff @(posedge clock) begin
        if (reset) pc <= '0;
        else       pc <= pc_next;
    end
endmodule

module ram #(
    parameter int ADDR_SIZE = 18,
    parameter int WORD_SIZE = 18,
    parameter int MEM_SIZE  = 1024
) (
    input  logic                 clock,
    input  logic                 we,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [WORD_SIZE-1:0] din,
    output logic [WORD_SIZE-1:0] dout
);
    localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

    logic [WORD_SIZE-1:0] mem [0:MEM_SIZE-1];
    logic [IDX_W-1:0]     idx;
    logic                 in_range;

    assign idx      = addr[IDX_W-1:0];
    assign in_range = (addr < ADDR_SIZE'(MEM_SIZE));
    assign dout     = in_range ? mem[idx] : '0;

    always_ff @(posedge clock) begin
        if (we && in_range) mem[idx] <= din;
    end
endmodule

// File: tb/tb_processor.sv
// tb/tb_processor.sv - scoreboard bench for processor against an arithmetic reference model
module tb_processor;
    logic        clock;
    logic        reset;
    logic [17:0] code_addr;
    logic [17:0] code_word;
    logic        memory_write_enable;
    logic [17:0] memory_addr;
    logic [17:0] memory_in;
    logic [17:0] memory_out;

    logic [17:0] code [256];

    processor #(.ADDR_SIZE(18), .WORD_SIZE(18)) dut (
        .clock               (clock),
        .reset               (reset),
        .code_addr           (code_addr),
        .code_word           (code_word),
        .memory_write_enable (memory_write_enable),
        .memory_addr         (memory_addr),
        .memory_in           (memory_in),
        .memory_out          (memory_out)
    );

    ram #(.ADDR_SIZE(18), .WORD_SIZE(18), .MEM_SIZE(256)) ram_i (
        .clock (clock),
        .we    (memory_write_enable),
        .addr  (memory_addr),
        .din   (memory_in),
        .dout  (memory_out)
    );

    assign code_word = (code_addr < 18'd256) ? code[code_addr[7:0]] : 18'd0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit               in_reset;
        logic [17:0]      pc;
        logic             we;
        logic [17:0]      maddr;
        logic [17:0]      min;
        logic [7:0][17:0] regs;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    // Reference state: registers and memory as signed integers, addresses as 0..2^18-1.
    int m_pc;
    int m_r [8];
    int m_mem [256];

    function automatic int wrap(input int x);
        int y;
        y = x % 262144;
        if (y < 0) y += 262144;
        if (y >= 131072) y -= 262144;
        return y;
    endfunction

    function automatic int umod(input int x);
        int y;
        y = x % 262144;
        if (y < 0) y += 262144;
        return y;
    endfunction

    function automatic logic [17:0] fetch(input int p);
        if (p < 256) return code[p];
        return 18'd0;
    endfunction

    function void chk(input string name, input logic [17:0] act, input logic [17:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %05h expected %05h at %0t", name, act, exp_v, $time);
        end
    endfunction

    task automatic model_exec(input logic [17:0] w);
        int op, a, b, c, f, s8, s11, rb, rc, addr;
        bit t;
        op  = int'(w[17:14]);
        a   = int'(w[13:11]);
        b   = int'(w[10:8]);
        c   = int'(w[7:5]);
        f   = int'(w[3:0]);
        s8  = int'(w[7:0]);  if (s8 >= 128) s8 -= 256;
        s11 = int'(w[10:0]); if (s11 >= 1024) s11 -= 2048;
        rb  = m_r[b];
        rc  = m_r[c];
        addr = umod(rb + s8);
        m_pc = umod(m_pc + 1);
        case (op)
            0: case (f)
                0: m_r[a] = wrap(rb + rc);
                1: m_r[a] = wrap(rb - rc);
                2: m_r[a] = wrap(rb & rc);
                3: m_r[a] = wrap(rb | rc);
                4: m_r[a] = wrap(rb ^ rc);
                5: m_r[a] = wrap(-rc - 1);
                default: m_r[a] = rb;
            endcase
            1: m_r[a] = s11;
            2: m_r[a] = wrap(m_r[a] + s8);
            3: m_r[a] = (addr < 256) ? m_mem[addr] : 0;
            4: if (addr < 256) m_mem[addr] = m_r[a];
            5: begin
                case (a)
                    0: t = (rb == 0);
                    1: t = (rb < 0);
                    2: t = (rb > 0);
                    3: t = (rb <= 0);
                    4: t = (rb >= 0);
                    5: t = ((rb & 1) == 0);
                    6: t = ((rb & 1) == 1);
                    default: t = 1'b1;
                endcase
                if (t) m_pc = umod(m_pc + s8);
            end
            default: ;
        endcase
    endtask

    // Drive one clock: predict this cycle's outputs, queue them, advance the model.
    task automatic step(input bit rst);
        exp_t e;
        logic [17:0] w;
        int op, s8;
        reset = rst;
        w  = fetch(m_pc);
        op = int'(w[17:14]);
        s8 = int'(w[7:0]); if (s8 >= 128) s8 -= 256;
        e.in_reset = rst;
        e.pc    = 18'(m_pc);
        e.we    = (op == 4) && !rst;
        e.maddr = (op == 3 || op == 4) ? 18'(umod(m_r[int'(w[10:8])] + s8)) : 18'd0;
        e.min   = (op == 4) ? 18'(m_r[int'(w[13:11])]) : 18'd0;
        for (int i = 0; i < 8; i++) e.regs[i] = 18'(m_r[i]);
        sb.push_back(e);
        if (rst) begin
            m_pc = 0;
            for (int i = 0; i < 8; i++) m_r[i] = 0;
        end else begin
            model_exec(w);
        end
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("we", 18'(memory_write_enable), 18'(e.we));
            if (!e.in_reset) begin
                chk("pc", code_addr, e.pc);
                chk("maddr", memory_addr, e.maddr);
                chk("min", memory_in, e.min);
                for (int i = 0; i < 8; i++)
                    chk($sformatf("r%0d", i), dut.registers.regs[i], e.regs[i]);
            end
        end
    end

    function automatic logic [17:0] enc_alu(input int a, input int b, input int c, input int f);
        return {4'd0, 3'(a), 3'(b), 3'(c), 1'b0, 4'(f)};
    endfunction

    function automatic logic [17:0] enc_ldi(input int a, input int v);
        return {4'd1, 3'(a), 11'(v)};
    endfunction

    function automatic logic [17:0] enc_ri(input int op, input int a, input int b, input int imm);
        return {4'(op), 3'(a), 3'(b), 8'(imm)};
    endfunction

    task automatic clear_code;
        for (int i = 0; i < 256; i++) code[i] = enc_ri(5, 7, 0, -1);
    endtask

    initial begin
        reset = 1'b1;
        m_pc = 0;
        for (int i = 0; i < 8; i++) m_r[i] = 0;
        for (int i = 0; i < 256; i++) m_mem[i] = 0;

        // Zero the data ram with a store loop so later loads are defined.
        clear_code();
        code[0] = enc_ldi(0, 0);
        code[1] = enc_ldi(1, 0);
        code[2] = enc_ldi(2, 256);
        code[3] = enc_ri(4, 0, 1, 0);
        code[4] = enc_ri(2, 1, 0, 1);
        code[5] = enc_ri(2, 2, 0, -1);
        code[6] = enc_ri(5, 2, 2, -4);
        @(posedge clock); #1;
        step(1); step(1);
        for (int i = 0; i < 1040; i++) step(0);
        chk("init_halt_pc", code_addr, 18'd7);

        clear_code();
        code[0]  = enc_ldi(0, 1);
        code[1]  = enc_ldi(1, 2);
        code[2]  = enc_alu(2, 0, 1, 0);
        code[3]  = enc_ldi(0, 5);
        code[4]  = enc_ldi(1, 2);
        code[5]  = enc_ri(4, 0, 1, 1);
        code[6]  = enc_ri(3, 3, 1, 1);
        code[7]  = enc_ldi(4, -1024);
        for (int i = 8; i < 15; i++) code[i] = enc_alu(4, 4, 4, 0);
        code[15] = enc_alu(0, 1, 4, 5);
        code[16] = enc_ldi(1, 1);
        code[17] = enc_alu(5, 0, 1, 0);
        code[18] = enc_ldi(0, 2);
        code[19] = enc_ri(5, 5, 0, 1);
        code[20] = enc_ldi(6, 7);
        code[21] = enc_ri(5, 6, 0, 1);
        code[22] = enc_ldi(6, 1);
        code[23] = enc_ldi(0, -1);
        code[24] = enc_ri(5, 2, 0, 1);
        code[25] = enc_ldi(7, 3);
        code[26] = enc_ri(5, 6, 0, 1);
        code[27] = enc_ldi(7, 9);
        code[28] = enc_ldi(0, 0);
        code[29] = enc_ri(5, 0, 0, -1);
        step(1);
        step(0); step(0); step(0);
        chk("ldi_add_r2", dut.registers.regs[2], 18'd3);
        chk("ldi_add_pc", code_addr, 18'd3);
        for (int i = 0; i < 4; i++) step(0);
        chk("load_r3", dut.registers.regs[3], 18'd5);
        chk("store_mem3", ram_i.mem[3], 18'd5);
        for (int i = 0; i < 40; i++) step(0);
        chk("loop_pc", code_addr, 18'd29);
        chk("double_r4", dut.registers.regs[4], 18'h20000);
        chk("wrap_r5", dut.registers.regs[5], 18'h20000);
        chk("bit_test_r6", dut.registers.regs[6], 18'd1);
        chk("branch_r7", dut.registers.regs[7], 18'd3);

        clear_code();
        code[0] = enc_ldi(0, 7);
        code[1] = enc_ldi(1, 10);
        code[2] = enc_ri(4, 0, 1, 0);
        step(1);
        step(0); step(0);
        step(1);
        chk("abort_mem10", ram_i.mem[10], 18'd0);
        chk("abort_pc", code_addr, 18'd0);
        chk("abort_r0", dut.registers.regs[0], 18'd0);
        chk("abort_r1", dut.registers.regs[1], 18'd0);
        for (int i = 0; i < 4; i++) step(0);

        for (int p = 0; p < 5; p++) begin
            step(1);
            for (int i = 0; i < 256; i++) begin
                int op;
                op = ($urandom_range(0, 4) == 0) ? $urandom_range(6, 15) : $urandom_range(0, 5);
                code[i] = {4'(op), 14'($urandom)};
                if (op == 3 || op == 4) code[i][10:8] = 3'($urandom_range(0, 1));
            end
            code[0] = enc_ldi(0, $urandom_range(0, 200));
            code[1] = enc_ldi(1, $urandom_range(0, 40));
            step(1);
            for (int i = 0; i < 300; i++) step(0);
        end

        @(negedge clock);
        for (int i = 0; i < 256; i++)
            chk($sformatf("mem%0d", i), ram_i.mem[i], 18'(m_mem[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/processor.md
PROCESSOR -- requirements
Module: processor

Interface
REQ-001 Parameter ADDR_SIZE, default 18: width of code and data address buses.
REQ-002 Parameter WORD_SIZE, default 18: width of instruction, data and register words.
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 code_addr  output  ADDR_SIZE  program counter (PC), driven combinationally from the PC register.
REQ-006 code_word  input  WORD_SIZE  instruction at code_addr, valid in the same cycle (asynchronous code memory).
REQ-007 memory_write_enable  output  1  data write strobe, high for exactly the STORE cycle.
REQ-008 memory_addr  output  ADDR_SIZE  data address for LOAD/STORE; 0 in all other cycles.
REQ-009 memory_in  output  WORD_SIZE  store data, to the data memory din.
REQ-010 memory_out  input  WORD_SIZE  load data, from the data memory dout; combinational read of memory_addr.

Function
REQ-011 The processor SHALL execute one instruction per clock, single-cycle, with no pipeline and no stalls.
REQ-012 The register file SHALL be hierarchically named registers.regs[0..7], with eight WORD_SIZE general registers, all two's-complement.
REQ-013 The PC SHALL advance to PC+1 each cycle unless a taken branch occurs; PC arithmetic wraps modulo 2^ADDR_SIZE.
REQ-014 Opcode fields: op=code_word[17:14], reg A=[13:11], reg B=[10:8], reg C=[7:5], imm8=[7:0], imm11=[10:0].
REQ-015 op 0 ALU: regs[A] <= regs[B] aluop regs[C], where aluop=[3:0].
REQ-016 ALU ops: 0 ADD, 1 SUB (B-C), 2 AND, 3 OR, 4 XOR, 5 NOT (~regs[C]); ops 6-15 pass regs[B].
REQ-017 ALU overflow SHALL wrap modulo 2^18 (131071+1 = -131072) and set no flags.
REQ-018 op 1 LDI: regs[A] <= sign-extend(imm11).
REQ-019 op 2 ADDI: regs[A] <= regs[A] + sign-extend(imm8); field [10:8] is ignored.
REQ-020 op 3 LOAD: memory_addr = regs[B] + sext(imm8); regs[A] <= memory_out at the clock edge.
REQ-021 op 4 STORE: memory_addr = regs[B] + sext(imm8); memory_in = regs[A]; memory_write_enable = 1.
REQ-022 op 5 BRANCH: when cond([13:11]) holds on regs[B], PC <= PC + 1 + sext(imm8); otherwise PC+1.
REQ-023 Branch conditions, signed compare on regs[B]:
- 0 ==0
- 1 <0
- 2 >0
- 3 <=0
- 4 >=0
- 5 bit0 clear
- 6 bit0 set
- 7 always
REQ-024 ops 6-15 SHALL be NOP (PC+1 only).
REQ-025 Outside STORE, memory_write_enable=0 and memory_in=0.
REQ-026 Writes to any register index, including 7, are ordinary; all eight registers are identical.
REQ-027 Within one instruction, register reads see pre-edge values; a destination equal to a source uses the old value.
REQ-028 Companion ram (ports clock, we, addr, din, dout; parameters ADDR_SIZE, WORD_SIZE, MEM_SIZE) behaviour:
- write on the rising edge when we=1
- dout = mem[addr] combinational
- addr >= MEM_SIZE: read returns 0, write ignored

Reset
REQ-029 While reset=1 at a clock edge: PC <= 0 and all regs <= 0; no register or memory write occurs.
REQ-030 During reset, memory_write_enable SHALL be 0 combinationally.
REQ-031 Execution SHALL start at address 0 on the first edge after reset falls.
REQ-032 Reset asserted mid-program SHALL abort the current instruction; no write takes effect.

Verification
REQ-033 Scenario LDI/ADD: LDI r0,1; LDI r1,2; ALU ADD r2=r0+r1 -> r2=3 after the third edge; code_addr=3.
REQ-034 Scenario wrap/NOT: r0=131071, r1=1, ADD -> -131072. NOT with regs[C]=18'b100101111010100111 -> 18'b011010000101011000.
REQ-035 Scenario memory: LDI r0,5; LDI r1,2; STORE r0,[r1+1] -> mem[3]=5 with we high one cycle; LOAD r3,[r1+1] -> r3=5.
REQ-036 Scenario branch: r0=0, BRANCH cond0 on r0, imm8=-1 -> PC holds, infinite loop. r0=-1 with cond2 -> not taken, PC+1.
REQ-037 Scenario bit test: r0=2 -> cond5 taken, cond6 not taken. r0=-1 -> cond6 taken.
REQ-038 Scenario reset mid-run: assert reset during a STORE -> no memory write; PC=0 and all regs=0 next cycle.
